// File: rtl/online_result_deserializer.sv
// online_result_deserializer
//   Receive end of the online multiplier output stream. Skips the online delay after
//   start, captures out_digits MSD-first signed digits, and converts them on the fly
//   (Q/QM pair) into a two's-complement word. The result is offered on valid/ready.
//   Optional build macro: OTF_DIGIT_CHECK_EN adds a sticky illegal-digit (-4) flag.
module online_result_deserializer #(
    parameter int unsigned no_of_digits = 4,
    parameter int unsigned radix_bits   = 3,
    parameter int unsigned radix        = 4,
    parameter int unsigned delta        = 2,
    parameter int unsigned out_digits   = 2*no_of_digits+1
) (
    input  logic                             clk,
    input  logic                             extern_reset_n,
    input  logic                             start,
    input  logic [radix_bits-1:0]            z,
    input  logic                             ready,
    output logic                             valid,
    output logic                             busy,
    output logic [out_digits*radix_bits-1:0] dout_raw,
    output logic [2*out_digits:0]            result_tc,
    output logic                             digit_err
);

    localparam int unsigned RES_W  = 2*out_digits+1;
    localparam int unsigned RAW_W  = out_digits*radix_bits;
    localparam int unsigned SH     = $clog2(radix);
    localparam int unsigned CNT_W  = $clog2(out_digits+1);
    localparam int unsigned SKIP_W = (delta > 0) ? $clog2(delta+1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q;
    logic                valid_q;
    logic                busy_q;
    logic [RAW_W-1:0]    dout_q;
    logic [RES_W-1:0]    q_q;
    logic [RES_W-1:0]    qm_q;
    logic [SKIP_W-1:0]   skip_cnt_q;
    logic [CNT_W-1:0]    dig_cnt_q;

    logic [RES_W-1:0]    q_d;
    logic [RES_W-1:0]    qm_d;
    logic [SH-1:0]       dm1;
    logic                z_neg;
    logic                z_pos;
    logic                z_min;
    logic                accept_start;

    assign valid     = valid_q;
    assign busy      = busy_q;
    assign dout_raw  = dout_q;
    assign result_tc = q_q;

    // A new frame starts from IDLE, or straight out of DONE when the result is taken
    assign accept_start = start && ((state_q == IDLE) || ((state_q == DONE) && ready));

    // Digit classification and on-the-fly conversion next values
    always_comb begin
        z_neg = z[radix_bits-1];
        z_pos = !z[radix_bits-1] && (z != '0);
        z_min = (z == {1'b1, {(radix_bits-1){1'b0}}});
        // low digit of Q is d mod radix; low digit of QM is (d-1) mod radix
        dm1   = z[SH-1:0] - SH'(1);
        q_d   = z_neg ? {qm_q[RES_W-SH-1:0], z[SH-1:0]}
                      : {q_q[RES_W-SH-1:0],  z[SH-1:0]};
        if (z_min) begin
            // -4 still converts arithmetically: QM' = 4*QM - 1 needs a borrow into the upper part
            qm_d = {(RES_W-SH)'(qm_q[RES_W-SH-1:0] - (RES_W-SH)'(1)), {SH{1'b1}}};
        end else if (z_pos) begin
            qm_d = {q_q[RES_W-SH-1:0], dm1};
        end else begin
            qm_d = {qm_q[RES_W-SH-1:0], dm1};
        end
    end

    // Frame FSM: skip the online delay, collect digits, hold the result until accepted
    always_ff @(posedge clk or negedge extern_reset_n) begin
        if (!extern_reset_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            dout_q     <= '0;
            q_q        <= '0;
            qm_q       <= '1;
            skip_cnt_q <= '0;
            dig_cnt_q  <= '0;
        end else if (accept_start) begin
            state_q    <= (delta == 0) ? COLLECT : SKIP;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
            dout_q     <= '0;
            q_q        <= '0;
            qm_q       <= '1;
            skip_cnt_q <= '0;
            dig_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                SKIP: begin
                    skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_q == SKIP_W'(delta-1)) begin
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    dout_q    <= {dout_q[RAW_W-radix_bits-1:0], z};
                    q_q       <= q_d;
                    qm_q      <= qm_d;
                    dig_cnt_q <= dig_cnt_q + CNT_W'(1);
                    if (dig_cnt_q == CNT_W'(out_digits-1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef OTF_DIGIT_CHECK_EN
    logic digit_err_q;

    assign digit_err = digit_err_q;

    // Sticky flag for a -4 digit seen during collection, cleared by the next accepted start
    always_ff @(posedge clk or negedge extern_reset_n) begin
        if (!extern_reset_n) begin
            digit_err_q <= 1'b0;
        end else if (accept_start) begin
            digit_err_q <= 1'b0;
        end else if ((state_q == COLLECT) && z_min) begin
            digit_err_q <= 1'b1;
        end
    end
`else
    assign digit_err = 1'b0;
`endif

endmodule

// File: tb/tb_online_result_deserializer.sv
// Bench for online_result_deserializer: directed frames plus randomized digit streams,
// compared against the integer value of the digit string computed in the bench.
module tb_online_result_deserializer;

    localparam int OD  = 9;
    localparam int RW  = 2*OD+1;
    localparam int ZW  = 3*OD;
    localparam int DLT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    z;
    logic          ready;
    logic          valid;
    logic          busy;
    logic [ZW-1:0] dout_raw;
    logic [RW-1:0] result_tc;
    logic          digit_err;

    int checks = 0;
    int errors = 0;
    int digs[OD];

    online_result_deserializer dut (
        .clk            (clk),
        .extern_reset_n (rst_n),
        .start          (start),
        .z              (z),
        .ready          (ready),
        .valid          (valid),
        .busy           (busy),
        .dout_raw       (dout_raw),
        .result_tc      (result_tc),
        .digit_err      (digit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value of the digit string sum d_i * 4^(OD-1-i), wrapped to RW bits
    function automatic logic [63:0] model_val(input int n);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 4 + longint'(digs[i]);
        return 64'(v) & ((64'd1 << RW) - 64'd1);
    endfunction

    function automatic logic [63:0] model_raw();
        logic [63:0] r = '0;
        for (int i = 0; i < OD; i++) r = (r << 3) | 64'(digs[i] & 7);
        return r & ((64'd1 << ZW) - 64'd1);
    endfunction

    function automatic logic has_min();
        logic h = 1'b0;
        for (int i = 0; i < OD; i++) if (digs[i] == -4) h = 1'b1;
        return h;
    endfunction

    task automatic begin_frame();
        start = 1'b1;
        z     = 3'($urandom);
        tick();
        start = 1'b0;
    endtask

    // Drives the skip and collect cycles after the start edge and checks the result
    task automatic run_body(input string tag);
        logic exp_err;
        check({tag, "_e0_busy"}, 64'(busy), 64'd1);
        check({tag, "_e0_valid"}, 64'(valid), 64'd0);
        check({tag, "_e0_err"}, 64'(digit_err), 64'd0);
        for (int k = 0; k < DLT; k++) begin
            z     = 3'($urandom);
            start = 1'($urandom_range(0, 1));
            tick();
            check({tag, "_skip_busy"}, 64'(busy), 64'd1);
        end
        for (int i = 0; i < OD; i++) begin
            z     = 3'(digs[i]);
            start = 1'($urandom_range(0, 1));
            tick();
            if (i < OD - 1) begin
                check({tag, "_col_busy"}, 64'(busy), 64'd1);
                check({tag, "_col_valid"}, 64'(valid), 64'd0);
            end
        end
        start = 1'b0;
        z     = 3'($urandom);
`ifdef OTF_DIGIT_CHECK_EN
        exp_err = has_min();
`else
        exp_err = 1'b0;
`endif
        check({tag, "_valid"}, 64'(valid), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_result"}, 64'(result_tc), model_val(OD));
        check({tag, "_raw"}, 64'(dout_raw), model_raw());
        check({tag, "_err"}, 64'(digit_err), 64'(exp_err));
    endtask

    task automatic do_frame(input string tag);
        begin_frame();
        run_body(tag);
        tick();
        check({tag, "_idle_valid"}, 64'(valid), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        rst_n = 1'b0;
        start = 1'b0;
        z     = 3'd0;
        ready = 1'b1;
        #12;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result_tc), 64'd0);
        check("rst_raw", 64'(dout_raw), 64'd0);
        check("rst_err", 64'(digit_err), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: all-zero frame
        foreach (digs[i]) digs[i] = 0;
        do_frame("t1_zero");

        // 2: MSD one, rest zero -> 4^8
        foreach (digs[i]) digs[i] = 0;
        digs[0] = 1;
        do_frame("t2_msd");
        check("t2_const", model_val(OD), 64'h10000);

        // 3: zeros then -1 -> all ones
        foreach (digs[i]) digs[i] = 0;
        digs[OD-1] = -1;
        do_frame("t3_neg1");

        // 4: 1,-1 then zeros -> 4^8 - 4^7
        foreach (digs[i]) digs[i] = 0;
        digs[0] = 1;
        digs[1] = -1;
        do_frame("t4_qm");

        // -4 digits: arithmetic conversion and the sticky flag
        foreach (digs[i]) digs[i] = 0;
        digs[0] = -4;
        digs[3] = -4;
        digs[8] = 2;
        do_frame("t_min4");

        // 5: hold in DONE with ready low while start pulses, then ready+start together
        ready = 1'b0;
        foreach (digs[i]) digs[i] = $urandom_range(0, 6) - 3;
        begin_frame();
        run_body("t5_hold");
        held = model_val(OD);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            tick();
            check("t5_hold_valid", 64'(valid), 64'd1);
            check("t5_hold_busy", 64'(busy), 64'd0);
            check("t5_hold_result", 64'(result_tc), held);
        end
        foreach (digs[i]) digs[i] = $urandom_range(0, 6) - 3;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_body("t5_b2b");
        tick();
        check("t5_idle_valid", 64'(valid), 64'd0);

        // 6: asynchronous reset in the middle of collection
        foreach (digs[i]) digs[i] = $urandom_range(0, 6) - 3;
        digs[0] = 3;
        begin_frame();
        for (int k = 0; k < DLT; k++) tick();
        for (int i = 0; i < 4; i++) begin
            z = 3'(digs[i]);
            tick();
        end
        check("t6_partial", 64'(result_tc), model_val(4));
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", 64'(valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_result", 64'(result_tc), 64'd0);
        check("t6_raw", 64'(dout_raw), 64'd0);
        check("t6_err", 64'(digit_err), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        check("t6_idle_busy", 64'(busy), 64'd0);

        // Randomized frames with random downstream back-pressure
        for (int f = 0; f < 30; f++) begin
            int wait_n;
            foreach (digs[i]) begin
                if ((f % 4) == 3) digs[i] = $urandom_range(0, 7) - 4;
                else              digs[i] = $urandom_range(0, 6) - 3;
            end
            wait_n = $urandom_range(0, 3);
            ready  = (wait_n == 0);
            begin_frame();
            run_body("rnd");
            held = model_val(OD);
            for (int w = 0; w < wait_n; w++) begin
                tick();
                check("rnd_wait_valid", 64'(valid), 64'd1);
                check("rnd_wait_result", 64'(result_tc), held);
            end
            ready = 1'b1;
            tick();
            check("rnd_idle_valid", 64'(valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
